// File: rtl/jk_pkg.sv
// Shared JK flip-flop command encodings and next-state function.
// A command is {J, K}; jk_next gives the flop state after one clock edge.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    function automatic logic jk_next(input logic [1:0] cmd, input logic q);
        logic r;
        case (cmd)
            JK_RST:  r = 1'b0;
            JK_SET:  r = 1'b1;
            JK_TGL:  r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low clear.
module jk_cell
    import jk_pkg::*;
(
    input  logic CK,
    input  logic CLR,
    input  logic J,
    input  logic K,
    output logic Q
);

    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            Q <= 1'b0;
        end else begin
            Q <= jk_next({J, K}, Q);
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from a bank of JK cells, with synchronous
// clear/load/enable, a cascade terminal-count output and wrap/load-error pulses.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
    input  logic             SCLR,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP,
    output logic             LERR
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("jk_mod_counter: WIDTH must be 1..16");
    end
    if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic             force_ld;
    logic             cnt;
    logic [WIDTH-1:0] nxt;
    logic             wrap_d;
    logic             lerr_d;
    logic [1:0]       cmd [WIDTH];

    // Decide per edge whether the bank counts, or is forced to an explicit value.
    always_comb begin
        force_ld = 1'b0;
        cnt      = 1'b0;
        nxt      = '0;
        wrap_d   = 1'b0;
        lerr_d   = 1'b0;
        if (SCLR) begin
            force_ld = 1'b1;
        end else if (LD) begin
            force_ld = 1'b1;
            if (32'(D) < MODULUS) begin
                nxt = D;
            end else begin
                nxt    = LAST;
                lerr_d = 1'b1;
            end
        end else if (EN) begin
            if (UP && Q == LAST) begin
                force_ld = 1'b1;
                wrap_d   = 1'b1;
            end else if (!UP && Q == '0) begin
                force_ld = 1'b1;
                nxt      = LAST;
                wrap_d   = 1'b1;
            end else begin
                cnt = 1'b1;
            end
        end
    end

    // Ripple toggle enable: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (force_ld) begin
                cmd[i] = nxt[i] ? JK_SET : JK_RST;
            end else if (cnt && carry) begin
                cmd[i] = JK_TGL;
            end else begin
                cmd[i] = JK_HOLD;
            end
            carry = carry & (UP ? Q[i] : ~Q[i]);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_cell u_cell (
            .CK  (CK),
            .CLR (CLR),
            .J   (cmd[i][1]),
            .K   (cmd[i][0]),
            .Q   (Q[i])
        );
    end

    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            WRAP <= 1'b0;
            LERR <= 1'b0;
        end else begin
            WRAP <= wrap_d;
            LERR <= lerr_d;
        end
    end

    assign TC = EN & (UP ? (Q == LAST) : (Q == '0));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: arithmetic reference model checked every
// cycle, literal expectations for the listed scenarios, and a two-digit cascade.
module tb_jk_mod_counter;

    localparam int M = 10;

    logic       CK = 1'b0;
    logic       CLR = 1'b0;
    logic       en = 1'b0, up = 1'b1, ld = 1'b0, sclr = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] q;
    logic       tc, wrap, lerr;

    logic       c_en = 1'b0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_lerr, hi_lerr;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    int m_q = 0;
    bit m_wrap = 1'b0, m_lerr = 1'b0;

    always #5 CK = ~CK;

    jk_mod_counter #(.WIDTH(4), .MODULUS(M)) dut (
        .CK(CK), .CLR(CLR), .EN(en), .UP(up), .LD(ld), .SCLR(sclr), .D(d),
        .Q(q), .TC(tc), .WRAP(wrap), .LERR(lerr)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(M)) lo (
        .CK(CK), .CLR(CLR), .EN(c_en), .UP(1'b1), .LD(1'b0), .SCLR(1'b0), .D(4'd0),
        .Q(lo_q), .TC(lo_tc), .WRAP(lo_wrap), .LERR(lo_lerr)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(M)) hi (
        .CK(CK), .CLR(CLR), .EN(lo_tc), .UP(1'b1), .LD(1'b0), .SCLR(1'b0), .D(4'd0),
        .Q(hi_q), .TC(hi_tc), .WRAP(hi_wrap), .LERR(hi_lerr)
    );

    // Reference model: the counting rules as plain integer arithmetic.
    always @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            m_q = 0; m_wrap = 0; m_lerr = 0;
        end else begin
            m_wrap = 0; m_lerr = 0;
            if (sclr) begin
                m_q = 0;
            end else if (ld) begin
                if (int'(d) < M) m_q = int'(d);
                else begin m_q = M - 1; m_lerr = 1; end
            end else if (en) begin
                if (up) begin
                    m_wrap = (m_q == M - 1);
                    m_q = (m_q + 1) % M;
                end else begin
                    m_wrap = (m_q == 0);
                    m_q = (m_q + M - 1) % M;
                end
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CK) begin
        if (chk_on) begin
            int m_tc;
            m_tc = (en && (up ? (m_q == M - 1) : (m_q == 0))) ? 1 : 0;
            cmp("model_q", int'(q), m_q);
            cmp("model_tc", int'(tc), m_tc);
            cmp("model_wrap", int'(wrap), int'(m_wrap));
            cmp("model_lerr", int'(lerr), int'(m_lerr));
            cmp("range_dut", int'(q < 4'(M)), 1);
            cmp("range_lo", int'(lo_q < 4'(M)), 1);
            cmp("range_hi", int'(hi_q < 4'(M)), 1);
        end
    end

    // Inputs are set just after an edge; cyc applies them across the next edge.
    task automatic cyc(input logic s, input logic l, input logic e, input logic u, input logic [3:0] dv);
        sclr = s; ld = l; en = e; up = u; d = dv;
        @(posedge CK);
        #1;
    endtask

    initial begin
        int up_seq[12];
        int dn_seq[3];
        up_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        dn_seq = '{0, 9, 8};

        repeat (2) @(posedge CK);
        #1;
        CLR = 1'b1;
        chk_on = 1'b1;

        // 1. asynchronous reset mid-cycle, then first edge counts once
        cyc(0, 1, 0, 1, 4'd7);
        cmp("load7_q", int'(q), 7);
        sclr = 0; ld = 0; en = 1; up = 1;
        #2;
        CLR = 1'b0;
        #1;
        cmp("rst_q", int'(q), 0);
        cmp("rst_wrap", int'(wrap), 0);
        cmp("rst_lerr", int'(lerr), 0);
        @(posedge CK);
        #1;
        cmp("rst_held_q", int'(q), 0);
        CLR = 1'b1;
        cyc(0, 0, 1, 1, 4'd0);
        cmp("rst_first_edge_q", int'(q), 1);

        // 2. up count through the wrap
        cyc(1, 0, 0, 1, 4'd0);
        cmp("sclr_q", int'(q), 0);
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, 1, 1, 4'd0);
            cmp("up_seq_q", int'(q), up_seq[k]);
            cmp("up_wrap", int'(wrap), (k == 9) ? 1 : 0);
            cmp("up_tc", int'(tc), (up_seq[k] == 9) ? 1 : 0);
        end

        // 3. down count through the wrap
        cyc(0, 1, 0, 0, 4'd1);
        cmp("ld1_q", int'(q), 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0, 4'd0);
            cmp("dn_seq_q", int'(q), dn_seq[k]);
            cmp("dn_wrap", int'(wrap), (k == 1) ? 1 : 0);
            cmp("dn_tc", int'(tc), (k == 0) ? 1 : 0);
        end

        // 4. priority
        cyc(1, 1, 1, 1, 4'd5);
        cmp("prio_sclr_q", int'(q), 0);
        cyc(0, 1, 1, 1, 4'd5);
        cmp("prio_ld_q", int'(q), 5);

        // 5. out-of-range load then hold
        cyc(0, 1, 0, 1, 4'd12);
        cmp("badld_q", int'(q), 9);
        cmp("badld_lerr", int'(lerr), 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 4'd0);
            cmp("hold_q", int'(q), 9);
            cmp("hold_lerr", int'(lerr), 0);
        end

        // 6. two-digit cascade for 100 edges
        cmp("casc_start", int'(hi_q) * 10 + int'(lo_q), 0);
        c_en = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge CK);
            #1;
            cmp("casc_lo", int'(lo_q), n % 10);
            cmp("casc_hi", int'(hi_q), (n / 10) % 10);
            if (n == 100) cmp("casc_hi_wrap", int'(hi_wrap), 1);
            else if (n % 10 == 0) cmp("casc_lo_wrap", int'(lo_wrap), 1);
        end
        c_en = 1'b0;
        @(posedge CK);
        #1;
        cmp("casc_hi_wrap_end", int'(hi_wrap), 0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
